uart_rx_ctrl: RTL and testbench

Controller between the UART receiver and the CPU-side peripheral bus. It gates the receiver through its enable, stores received words in a show-ahead FIFO, and detects overrun and BREAK. It also raises level and idle-timeout interrupts, so software services the receiver per burst rather than per byte.

---
 rtl/uart_rx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_ctrl
// Brief  : UART receive controller: receiver gating, show-ahead FIFO,
//          overrun/BREAK detection, level and idle-timeout interrupts.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
   parameter int PAYLOAD_BITS   = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int IRQ_LEVEL      = 8,
   parameter int TIMEOUT_CYCLES = 208_330
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ctrl_enable,
   input  logic                          flush,
   input  logic                          rx_valid,
   input  logic [PAYLOAD_BITS-1:0]       rx_data,
   input  logic                          rx_break,
   output logic                          rx_en,
   input  logic                          rd_en,
   output logic [PAYLOAD_BITS-1:0]       rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overrun,
   output logic                          break_det,
   input  logic                          clr_flags,
   output logic                          level_irq,
   output logic                          timeout_irq
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_LW = c_AW + 1;
   // TIMEOUT_CYCLES >= 2 assumed, so the counter holds TIMEOUT_CYCLES-1.
   localparam int c_TW = $clog2(TIMEOUT_CYCLES);

   localparam logic [c_LW-1:0] c_FULL   = c_LW'(FIFO_DEPTH);
   localparam logic [c_LW-1:0] c_IRQ    = c_LW'(IRQ_LEVEL);
   localparam logic [c_TW-1:0] c_TMAX   = c_TW'(TIMEOUT_CYCLES - 1);
   localparam logic [c_TW-1:0] c_TPRE   = c_TW'(TIMEOUT_CYCLES - 2);

   localparam logic [1:0] c_OFF   = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_FLUSH = 2'd2;

   logic [1:0]              r_state;
   logic [1:0]              w_state_nxt;
   logic                    r_rx_en;
   logic                    w_rx_en_nxt;

   logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]         r_wr_ptr;
   logic [c_AW-1:0]         r_rd_ptr;
   logic [c_LW-1:0]         r_level;
   logic [c_LW-1:0]         w_level_nxt;
   logic                    r_level_irq;
   logic [c_TW-1:0]         r_tcnt;
   logic                    r_overrun;
   logic                    r_break;
   logic                    r_tirq;

   logic w_in_run, w_accept, w_push_req, w_pop, w_push, w_drop, w_brk;
   logic w_tmo_clear, w_tmo_inc, w_tmo_set;

   always_ff @(posedge clk or posedge reset) begin : p_state_reg
      if (reset) begin
         r_state <= c_OFF;
         r_rx_en <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rx_en <= w_rx_en_nxt;
      end
   end

   always_comb begin : p_state_nxt
      w_state_nxt = r_state;
      case (r_state)
         c_OFF:   if (ctrl_enable)  w_state_nxt = c_RUN;
         c_RUN:   if (!ctrl_enable) w_state_nxt = c_OFF;
         default: w_state_nxt = ctrl_enable ? c_RUN : c_OFF;
      endcase
      if (flush) w_state_nxt = c_FLUSH;
   end

   // rx_en is registered from the next state so it is high exactly in RUN.
   always_comb begin : p_state_out
      w_rx_en_nxt = (w_state_nxt == c_RUN);
   end

   assign w_in_run   = (r_state == c_RUN);
   assign w_accept   = w_in_run && rx_valid && !flush;
   assign w_push_req = w_accept && !rx_break;
   assign w_brk      = w_accept && rx_break;
   assign w_pop      = rd_en && !empty && !flush;
   assign w_push     = w_push_req && (!full || w_pop);
   assign w_drop     = w_push_req && full && !w_pop;

   always_comb begin : p_level_nxt
      w_level_nxt = r_level;
      if (w_push && !w_pop)      w_level_nxt = r_level + c_LW'(1);
      else if (w_pop && !w_push) w_level_nxt = r_level - c_LW'(1);
   end

   always_ff @(posedge clk) begin : p_mem
      if (w_push) r_mem[r_wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin : p_fifo
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_level_irq <= 1'b0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_level_irq <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         r_level     <= w_level_nxt;
         r_level_irq <= (w_level_nxt >= c_IRQ);
      end
   end

   // The timeout fires once, on the edge the counter reaches its maximum.
   assign w_tmo_clear = w_push || w_pop || empty;
   assign w_tmo_inc   = w_in_run && !w_tmo_clear && (r_tcnt != c_TMAX);
   assign w_tmo_set   = w_tmo_inc && (r_tcnt == c_TPRE);

   always_ff @(posedge clk or posedge reset) begin : p_flags
      if (reset) begin
         r_tcnt    <= '0;
         r_overrun <= 1'b0;
         r_break   <= 1'b0;
         r_tirq    <= 1'b0;
      end else if (flush) begin
         r_tcnt    <= '0;
         r_overrun <= 1'b0;
         r_break   <= 1'b0;
         r_tirq    <= 1'b0;
      end else begin
         if (w_tmo_clear)    r_tcnt <= '0;
         else if (w_tmo_inc) r_tcnt <= r_tcnt + c_TW'(1);

         if (w_drop)         r_overrun <= 1'b1;
         else if (clr_flags) r_overrun <= 1'b0;

         if (w_brk)          r_break <= 1'b1;
         else if (clr_flags) r_break <= 1'b0;

         if (w_tmo_set)                r_tirq <= 1'b1;
         else if (clr_flags || w_pop)  r_tirq <= 1'b0;
      end
   end

   assign rx_en       = r_rx_en;
   assign level       = r_level;
   assign empty       = (r_level == '0);
   assign full        = (r_level == c_FULL);
   assign rd_data     = empty ? '0 : r_mem[r_rd_ptr];
   assign overrun     = r_overrun;
   assign break_det   = r_break;
   assign level_irq   = r_level_irq;
   assign timeout_irq = r_tirq;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_ctrl
// Brief  : Self-checking bench for uart_rx_ctrl against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;

   localparam int PB    = 8;
   localparam int DEPTH = 16;
   localparam int IRQL  = 8;
   localparam int TMO   = 100;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ctrl_enable = 1'b0;
   logic          flush = 1'b0;
   logic          rx_valid = 1'b0;
   logic [PB-1:0] rx_data = '0;
   logic          rx_break = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_flags = 1'b0;
   logic          rx_en;
   logic [PB-1:0] rd_data;
   logic          empty;
   logic          full;
   logic [4:0]    level;
   logic          overrun;
   logic          break_det;
   logic          level_irq;
   logic          timeout_irq;

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .PAYLOAD_BITS   (PB),
      .FIFO_DEPTH     (DEPTH),
      .IRQ_LEVEL      (IRQL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ctrl_enable (ctrl_enable),
      .flush       (flush),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_break    (rx_break),
      .rx_en       (rx_en),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .level       (level),
      .overrun     (overrun),
      .break_det   (break_det),
      .clr_flags   (clr_flags),
      .level_irq   (level_irq),
      .timeout_irq (timeout_irq)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: contents as a queue, mode 0=off 1=run 2=flush, idle-cycle count.
   logic [PB-1:0] q[$];
   int            m_st;
   bit            m_ovr, m_brk, m_tirq;
   int            m_idle;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_st = 0; m_ovr = 0; m_brk = 0; m_tirq = 0; m_idle = 0;
   endtask

   task automatic model_edge();
      bit run, was_empty, push_req, brk, pop, drop, pushed, setev;
      if (reset) begin model_reset(); return; end
      if (flush) begin
         q.delete();
         m_ovr = 0; m_brk = 0; m_tirq = 0; m_idle = 0; m_st = 2;
         return;
      end
      run       = (m_st == 1);
      was_empty = (q.size() == 0);
      push_req  = run && rx_valid && !rx_break;
      brk       = run && rx_valid && rx_break;
      pop       = rd_en && !was_empty;
      drop      = push_req && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      pushed = push_req && !drop;
      if (pushed) q.push_back(rx_data);
      setev = 0;
      if (pushed || pop || was_empty) m_idle = 0;
      else if (run && m_idle < TMO - 1) begin
         m_idle++;
         setev = (m_idle == TMO - 1);
      end
      m_ovr  = drop  ? 1'b1 : (clr_flags ? 1'b0 : m_ovr);
      m_brk  = brk   ? 1'b1 : (clr_flags ? 1'b0 : m_brk);
      m_tirq = setev ? 1'b1 : ((clr_flags || pop) ? 1'b0 : m_tirq);
      m_st   = ctrl_enable ? 1 : 0;
   endtask

   task automatic compare_all();
      chk("rx_en",       32'(rx_en),       32'(m_st == 1));
      chk("level",       32'(level),       32'(q.size()));
      chk("empty",       32'(empty),       32'(q.size() == 0));
      chk("full",        32'(full),        32'(q.size() == DEPTH));
      chk("rd_data",     32'(rd_data),     (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("overrun",     32'(overrun),     32'(m_ovr));
      chk("break_det",   32'(break_det),   32'(m_brk));
      chk("level_irq",   32'(level_irq),   32'(q.size() >= IRQL));
      chk("timeout_irq", 32'(timeout_irq), 32'(m_tirq));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic push(input logic [PB-1:0] b);
      rx_valid = 1'b1; rx_data = b; rx_break = 1'b0;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin : main
      int n;
      int pv, pr;

      // Reset is checked before the first clock edge.
      reset = 1'b1;
      #2;
      model_reset();
      compare_all();
      chk("rst_empty", 32'(empty), 32'd1);
      step();
      reset = 1'b0;
      step();

      // Enable and a three-word burst.
      ctrl_enable = 1'b1;
      step();
      chk("t1_rx_en", 32'(rx_en), 32'd1);
      push(8'h41); push(8'h42); push(8'h43);
      chk("t1_level", 32'(level), 32'd3);
      chk("t1_head", 32'(rd_data), 32'h41);
      pop();
      chk("t1_pop1", 32'(rd_data), 32'h42);
      pop();
      chk("t1_pop2", 32'(rd_data), 32'h43);
      pop();
      chk("t1_empty", 32'(empty), 32'd1);

      // Fill, overflow, then push+pop while full.
      for (int i = 0; i < 16; i++) push(8'(i));
      push(8'hAA);
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_ovr", 32'(overrun), 32'd1);
      chk("t2_head", 32'(rd_data), 32'h00);
      clr_flags = 1'b1; step(); clr_flags = 1'b0;
      chk("t2_clr", 32'(overrun), 32'd0);
      rx_valid = 1'b1; rx_data = 8'hBB; rd_en = 1'b1;
      step();
      rx_valid = 1'b0; rd_en = 1'b0;
      chk("t2_lvl16", 32'(level), 32'd16);
      chk("t2_no_ovr", 32'(overrun), 32'd0);
      for (int i = 0; i < 15; i++) pop();
      chk("t2_tail", 32'(rd_data), 32'hBB);

      // BREAK does not write.
      rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'h00;
      step();
      rx_valid = 1'b0; rx_break = 1'b0;
      chk("t3_brk", 32'(break_det), 32'd1);
      chk("t3_level", 32'(level), 32'd1);
      clr_flags = 1'b1; step(); clr_flags = 1'b0;
      chk("t3_clr", 32'(break_det), 32'd0);
      pop();

      // Idle timeout, counted from the cycle carrying rx_valid.
      push(8'h77);
      n = 1;
      while (timeout_irq == 1'b0 && n < 300) begin
         step();
         n++;
      end
      chk("t4_tmo_cycles", 32'(n), 32'd100);
      pop();
      chk("t4_tmo_clr", 32'(timeout_irq), 32'd0);
      idle(150);
      chk("t4_empty_no_tmo", 32'(timeout_irq), 32'd0);

      // Level interrupt threshold.
      for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
      chk("t5_below", 32'(level_irq), 32'd0);
      push(8'h17);
      chk("t5_at", 32'(level_irq), 32'd1);
      pop();
      chk("t5_after_pop", 32'(level_irq), 32'd0);

      // BREAK, disable, late word, flush.
      rx_valid = 1'b1; rx_break = 1'b1; step(); rx_valid = 1'b0; rx_break = 1'b0;
      ctrl_enable = 1'b0;
      step();
      chk("t6_rx_en_off", 32'(rx_en), 32'd0);
      push(8'h55);
      chk("t6_retained", 32'(level), 32'd7);
      flush = 1'b1; step(); flush = 1'b0;
      chk("t6_flush_lvl", 32'(level), 32'd0);
      chk("t6_flush_brk", 32'(break_det), 32'd0);

      // Asynchronous reset mid-burst.
      ctrl_enable = 1'b1;
      step();
      push(8'h61); push(8'h62);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      chk("t6_rst_lvl", 32'(level), 32'd0);
      chk("t6_rst_rx_en", 32'(rx_en), 32'd0);
      step();
      reset = 1'b0;
      step();

      // Randomized segments with varying push/pop pressure.
      for (int seg = 0; seg < 24; seg++) begin
         pv = $urandom_range(0, 70);
         pr = $urandom_range(0, 70);
         if (seg % 4 == 3) begin pv = 0; pr = 0; end
         for (int c = 0; c < 160; c++) begin
            rx_valid  = ($urandom_range(0, 99) < pv);
            rx_break  = ($urandom_range(0, 99) < 4);
            rx_data   = 8'($urandom);
            rd_en     = ($urandom_range(0, 99) < pr);
            clr_flags = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 299) == 0) ctrl_enable = ~ctrl_enable;
            if (seg % 4 == 3) ctrl_enable = 1'b1;
            step();
         end
      end
      rx_valid = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; flush = 1'b0; rx_break = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
